conv1_layer: RTL and testbench

- Streaming 5x5 2-D convolution unit for the first CNN layer.
- Each clock it accepts one new 5-pixel column (4-bit unsigned pixels, input1 = top row, input5 = bottom row) into a 5-column sliding window.
- It convolves the window with a parameterised signed 5x5 kernel and applies arithmetic shift, ReLU and 8-bit saturation.
- It drives one registered 8-bit feature-map pixel per clock.

---
 rtl/conv1_layer.sv | 72 +++++++
 tb/tb_conv1_layer.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/conv1_layer.sv
// Streaming 5x5 convolution: one 5-pixel column in per clock, one clamped 8-bit pixel out per clock.
// Latency: a column captured at edge n first affects output1 after edge n+1. There is no backpressure.
module conv1_layer #(
  parameter logic [74:0] KERNEL = {25{3'b001}},
  parameter int          SHIFT  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] input1,
  input  logic [3:0] input2,
  input  logic [3:0] input3,
  input  logic [3:0] input4,
  input  logic [3:0] input5,
  output logic [7:0] output1
);

  logic        [3:0]  r_win [0:4][0:4];
  logic        [2:0]  r_cnt;
  logic        [3:0]  w_col [0:4];
  logic signed [15:0] w_sum;
  logic signed [15:0] w_k;
  logic signed [15:0] w_p;
  logic signed [15:0] w_shift;
  logic        [7:0]  w_pix;

  assign w_col[0] = input1;
  assign w_col[1] = input2;
  assign w_col[2] = input3;
  assign w_col[3] = input4;
  assign w_col[4] = input5;

  always_comb begin
    w_sum = '0;
    w_k   = '0;
    w_p   = '0;
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 5; c++) begin
        w_k   = 16'($signed(KERNEL[3*(r*5+c) +: 3]));
        w_p   = {12'd0, r_win[r][c]};
        w_sum = w_sum + w_k * w_p;
      end
    end
    w_shift = w_sum >>> SHIFT;
    if (w_shift < 16'sd0)
      w_pix = 8'd0;
    else if (w_shift > 16'sd255)
      w_pix = 8'd255;
    else
      w_pix = w_shift[7:0];
  end

  // Output is qualified by the pre-edge fill count, so it lags the window by one edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < 5; r++)
        for (int c = 0; c < 5; c++)
          r_win[r][c] <= 4'd0;
      r_cnt   <= 3'd0;
      output1 <= 8'd0;
    end else begin
      for (int r = 0; r < 5; r++) begin
        for (int c = 0; c < 4; c++)
          r_win[r][c] <= r_win[r][c+1];
        r_win[r][4] <= w_col[r];
      end
      if (r_cnt != 3'd5)
        r_cnt <= r_cnt + 3'd1;
      output1 <= (r_cnt == 3'd5) ? w_pix : 8'd0;
    end
  end

endmodule

// File: tb/tb_conv1_layer.sv
// Bench for conv1_layer: four kernel/shift variants driven in parallel, reference model feeding a scoreboard.
module tb_conv1_layer;

  function automatic logic [74:0] mk_ka();
    logic [74:0] k;
    k = '0;
    for (int i = 0; i < 25; i++)
      k[3*i +: 3] = 3'((i % 7) - 3);
    return k;
  endfunction

  localparam logic [74:0] K_P3 = {25{3'b011}};
  localparam logic [74:0] K_M1 = {25{3'b111}};
  localparam logic [74:0] K_AS = mk_ka();

  logic       clk;
  logic       rst_n;
  logic [3:0] in1, in2, in3, in4, in5;
  logic [7:0] o [0:3];

  int n_cmp;
  int n_err;
  int m_win [0:4][0:4];
  int m_cnt;
  int q [$];

  conv1_layer u_def (
    .clk(clk), .rst_n(rst_n), .input1(in1), .input2(in2), .input3(in3),
    .input4(in4), .input5(in5), .output1(o[0]));
  conv1_layer #(.KERNEL(K_P3), .SHIFT(0)) u_p3 (
    .clk(clk), .rst_n(rst_n), .input1(in1), .input2(in2), .input3(in3),
    .input4(in4), .input5(in5), .output1(o[1]));
  conv1_layer #(.KERNEL(K_M1), .SHIFT(1)) u_m1 (
    .clk(clk), .rst_n(rst_n), .input1(in1), .input2(in2), .input3(in3),
    .input4(in4), .input5(in5), .output1(o[2]));
  conv1_layer #(.KERNEL(K_AS), .SHIFT(2)) u_as (
    .clk(clk), .rst_n(rst_n), .input1(in1), .input2(in2), .input3(in3),
    .input4(in4), .input5(in5), .output1(o[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int kw(input int d, input int i);
    case (d)
      0:       return 1;
      1:       return 3;
      2:       return -1;
      default: return (i % 7) - 3;
    endcase
  endfunction

  function automatic int sh(input int d);
    case (d)
      0:       return 1;
      1:       return 0;
      2:       return 1;
      default: return 2;
    endcase
  endfunction

  function automatic int model_out(input int d);
    int s;
    if (m_cnt < 5) return 0;
    s = 0;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++)
        s += kw(d, r*5 + c) * m_win[r][c];
    s = s >>> sh(d);
    if (s < 0) return 0;
    if (s > 255) return 255;
    return s;
  endfunction

  task automatic model_clear();
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++)
        m_win[r][c] = 0;
    m_cnt = 0;
  endtask

  task automatic step(input int a, input int b, input int c, input int dd, input int e, input string tag);
    int col [0:4];
    col[0] = a; col[1] = b; col[2] = c; col[3] = dd; col[4] = e;
    in1 = 4'(a); in2 = 4'(b); in3 = 4'(c); in4 = 4'(dd); in5 = 4'(e);
    for (int d = 0; d < 4; d++)
      q.push_back(model_out(d));
    @(posedge clk);
    for (int r = 0; r < 5; r++) begin
      for (int k = 0; k < 4; k++)
        m_win[r][k] = m_win[r][k+1];
      m_win[r][4] = col[r];
    end
    if (m_cnt < 5) m_cnt++;
    #1;
    for (int d = 0; d < 4; d++)
      chk($sformatf("%s_dut%0d", tag, d), int'(o[d]), q.pop_front());
  endtask

  task automatic pulse_reset(input string tag);
    #2 rst_n = 1'b0;
    #1;
    for (int d = 0; d < 4; d++)
      chk($sformatf("%s_arst_dut%0d", tag, d), int'(o[d]), 0);
    #2 rst_n = 1'b1;
    model_clear();
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    model_clear();
    rst_n = 1'b0;
    in1 = '0; in2 = '0; in3 = '0; in4 = '0; in5 = '0;
    #2;
    for (int d = 0; d < 4; d++)
      chk($sformatf("rst_dut%0d", d), int'(o[d]), 0);
    #5 rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      step(15, 15, 15, 15, 15, "fill");
      chk("fill_zero", int'(o[0]), 0);
    end
    step(15, 15, 15, 15, 15, "full");
    chk("full_187", int'(o[0]), 187);
    chk("sat_255", int'(o[1]), 255);
    chk("relu_0", int'(o[2]), 0);
    step(15, 15, 15, 15, 15, "full2");
    chk("full_hold_187", int'(o[0]), 187);

    pulse_reset("mid");
    for (int i = 0; i < 5; i++) begin
      step(15, 15, 15, 15, 15, "refill");
      chk("refill_zero", int'(o[0]), 0);
    end
    step(15, 15, 15, 15, 15, "refull");
    chk("refull_187", int'(o[0]), 187);

    pulse_reset("slide");
    for (int i = 0; i < 5; i++)
      step(2, 2, 2, 2, 2, "slide2");
    step(4, 4, 4, 4, 4, "slide4a");
    chk("slide_25", int'(o[0]), 25);
    step(4, 4, 4, 4, 4, "slide4b");
    chk("slide_30", int'(o[0]), 30);
    for (int i = 0; i < 4; i++)
      step(4, 4, 4, 4, 4, "slide4c");
    chk("slide_50", int'(o[0]), 50);

    pulse_reset("strm");
    step(14, 7, 10, 9, 2, "strm");
    step(4, 5, 1, 8, 6, "strm");
    step(4, 12, 11, 5, 6, "strm");
    step(4, 7, 5, 2, 4, "strm");
    step(1, 1, 1, 1, 1, "strm");
    step(0, 0, 0, 0, 0, "strm");
    chk("strm_sum131", int'(o[0]), 65);

    for (int i = 0; i < 60; i++)
      step($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
           $urandom_range(0, 15), $urandom_range(0, 15), "rand");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
